// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice per clock, LSB first, start/busy/done handshake.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_adder_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;

  logic             bit_s;
  logic             bit_c;
  logic [WIDTH:0]   part_wide;
  logic [WIDTH-1:0] part_next;
  logic             finishing;

  // Single full-adder slice; the new sum bit enters at the MSB so the LSB lands at bit 0.
  assign bit_s     = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
  assign bit_c     = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
  assign part_wide = {bit_s, part_q};
  assign part_next = part_wide[WIDTH:1];
  assign finishing = (state_q == S_RUN) && (cnt_q == LAST);

  // NOTE: every next-state signal gets a default first so this block can never infer a latch.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    part_d  = part_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = cin;
          cnt_d   = '0;
          part_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        c_d    = bit_c;
        part_d = part_next;
        cnt_d  = cnt_q + CW'(1);
        if (finishing) begin
          sum_d   = part_next;
          cout_d  = bit_c;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; every register, datapath included, clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
  // Operand MSBs are kept aside because the shift registers have consumed them by completion.
  logic a_msb_q, b_msb_q, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && start) begin
        a_msb_q <= a[WIDTH-1];
        b_msb_q <= b[WIDTH-1];
      end
      if (finishing) begin
        ovf_q <= (a_msb_q == b_msb_q) && (part_next[WIDTH-1] != a_msb_q);
      end
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: stimulus pushes arithmetic expectations, a monitor
// pops them on each done pulse and also watches reset values, busy length and output holding.
module tb_serial_adder_ctrl;

  localparam int W = 64;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: plain integer addition, with overflow judged by whether the signed result fits.
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    exp_t                e;
    logic [W:0]          full;
    logic signed [W+1:0] s;
    logic signed [W+1:0] smax;
    logic signed [W+1:0] smin;
    full   = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
    s      = $signed({{2{ia[W-1]}}, ia}) + $signed({{2{ib[W-1]}}, ib})
           + $signed({{(W+1){1'b0}}, ic});
    smax   = $signed({3'b000, {(W-1){1'b1}}});
    smin   = $signed({3'b111, {(W-1){1'b0}}});
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (s > smax) || (s < smin);
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; waits for IDLE, then presents one accepted request.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    int guard = 0;
    while ((busy || done) && guard < 3 * W) begin
      tick(1);
      guard++;
    end
    check("idle_wait_timeout", guard >= 3 * W, 0);
    a     = ia;
    b     = ib;
    cin   = ic;
    start = 1'b1;
    exp_q.push_back(model(ia, ib, ic));
    tick(1);
    start = 1'b0;
    a     = {$urandom(), $urandom()};
    b     = {$urandom(), $urandom()};
    cin   = 1'($urandom());
    check("busy_after_start", busy, 1);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] v;
    v = {$urandom(), $urandom()};
    case ($urandom_range(0, 5))
      0:       v = '1;
      1:       v = '0;
      default: ;
    endcase
    return v;
  endfunction

  // Monitor: everything is sampled on the falling edge, away from the active edge.
  logic [W-1:0] prev_sum;
  logic         prev_cout;
  logic         prev_done;
  int           run_len;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outs", {busy, done, cout, sum}, 0);
      prev_sum  = '0;
      prev_cout = 1'b0;
      prev_done = 1'b0;
      run_len   = 0;
    end else begin
      exp_t e;
      if (busy) run_len++;
      check("busy_done_excl", busy & done, 0);
      if (done) begin
        check("done_single", prev_done, 0);
        check("busy_len", run_len, W);
        run_len = 0;
        check("done_expected", exp_q.size() == 0, 0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sum", sum, e.sum);
          check("cout", cout, e.cout);
`ifdef SERIAL_ADDER_OVF_EN
          check("ovf", ovf, e.ovf);
`endif
        end
      end else begin
        check("result_hold", {cout, sum}, {prev_cout, prev_sum});
      end
      prev_sum  = sum;
      prev_cout = cout;
      prev_done = done;
    end
  end

  initial begin
    int guard;
    rst_n = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #2;
    rst_n = 1'b0;
    start = 1'b1;
    a     = '1;
    b     = '1;
    cin   = 1'b1;
    tick(3);
    start = 1'b0;
    rst_n = 1'b1;
    tick(1);
    check("idle_after_reset", {busy, done}, 0);

    issue('0, '0, 1'b1);
    issue('1, '0, 1'b1);
    issue({1'b1, {(W-1){1'b0}}}, {1'b1, {(W-1){1'b0}}}, 1'b0);
    issue({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0);

    // Starts during RUN and DONE must be ignored.
    issue(W'(5), W'(7), 1'b0);
    for (int i = 1; i <= W; i++) begin
      start = (i == 10) || (i == W - 1) || (i == W);
      a     = W'(8'hFF);
      b     = W'(8'hFF);
      tick(1);
    end
    check("done_cycle", done, 1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("idle_after_done", {busy, done}, 0);
    issue(rnd_operand(), rnd_operand(), 1'($urandom()));

    // Reset in the middle of a run discards it.
    issue(rnd_operand(), rnd_operand(), 1'($urandom()));
    tick(29);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_outs", {busy, done, cout, sum}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    issue(W'(3), W'(4), 1'b1);

    for (int n = 0; n < 16; n++) begin
      issue(rnd_operand(), rnd_operand(), 1'($urandom()));
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 3 * W) begin
      tick(1);
      guard++;
    end
    tick(3);
    check("drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
